// File: rtl/riscv_fetch_pkg.sv
// rtl/riscv_fetch_pkg.sv - shared state encoding, fault codes and range helper for the fetch stage
package riscv_fetch_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'b00,
        FETCH  = 2'b01,
        HALTED = 2'b10,
        FAULT  = 2'b11
    } fetch_state_t;

    localparam logic [1:0]  FAULT_NONE           = 2'b00;
    localparam logic [1:0]  FAULT_MISALIGN       = 2'b01;
    localparam logic [1:0]  FAULT_RANGE          = 2'b10;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    // Byte address falls inside an instruction memory of depth words.
    function automatic logic addr_in_range(input logic [63:0] addr, input int unsigned depth);
        return (addr >> 2) < 64'(depth);
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - combinational next-PC candidate select with misalign and range flags
module pc_next_sel
    import riscv_fetch_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int IMEM_DEPTH    = 64
) (
    input  logic [ADDRESS_WIDTH-1:0] i_pc,
    input  logic                     i_stall,
    input  logic                     i_redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] i_redirect_target,
    output logic [ADDRESS_WIDTH-1:0] o_next_pc,
    output logic                     o_misaligned,
    output logic                     o_range
);

    logic [ADDRESS_WIDTH-1:0] w_seq_pc;

    assign w_seq_pc = i_pc + ADDRESS_WIDTH'(4);

    always_comb begin
        o_next_pc = w_seq_pc;
        if (i_redirect_valid) begin
            o_next_pc = i_redirect_target;
        end else if (i_stall) begin
            o_next_pc = i_pc;
        end
    end

    assign o_misaligned = i_redirect_valid && (i_redirect_target[1:0] != 2'b00);
    // Sequential wrap to 0 is already folded into w_seq_pc, so it is range-checked like any other candidate.
    assign o_range      = !addr_in_range(64'(o_next_pc), IMEM_DEPTH);

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register and fetch FSM; PC_FETCH_COUNTER_EN adds the fetch_count output
module pc_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = ADDRESS_WIDTH'(DEFAULT_RESET_VECTOR),
    parameter int                       IMEM_DEPTH    = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_target,
    input  logic                     halt_req,
    output logic [ADDRESS_WIDTH-1:0] pc,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4,
    output logic                     fetch_valid,
    output logic                     halted,
    output logic                     fault,
    output logic [1:0]               fault_code,
`ifdef PC_FETCH_COUNTER_EN
    output logic [ADDRESS_WIDTH-1:0] fault_addr,
    output logic [31:0]              fetch_count
`else
    output logic [ADDRESS_WIDTH-1:0] fault_addr
`endif
);

    localparam logic RV_IN_RANGE = addr_in_range(64'(RESET_VECTOR), IMEM_DEPTH);

    fetch_state_t             r_state;
    fetch_state_t             w_state_nxt;
    logic [ADDRESS_WIDTH-1:0] r_pc;
    logic [ADDRESS_WIDTH-1:0] w_pc_nxt;
    logic [1:0]               r_fault_code;
    logic [1:0]               w_fault_code_nxt;
    logic [ADDRESS_WIDTH-1:0] r_fault_addr;
    logic [ADDRESS_WIDTH-1:0] w_fault_addr_nxt;
    logic [ADDRESS_WIDTH-1:0] w_cand_pc;
    logic                     w_misaligned;
    logic                     w_range;

    pc_next_sel #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .IMEM_DEPTH    (IMEM_DEPTH)
    ) u_pc_next_sel (
        .i_pc              (r_pc),
        .i_stall           (stall),
        .i_redirect_valid  (redirect_valid),
        .i_redirect_target (redirect_target),
        .o_next_pc         (w_cand_pc),
        .o_misaligned      (w_misaligned),
        .o_range           (w_range)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= BOOT;
            r_pc         <= RESET_VECTOR;
            r_fault_code <= FAULT_NONE;
            r_fault_addr <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_fault_code <= w_fault_code_nxt;
            r_fault_addr <= w_fault_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_fault_code_nxt = r_fault_code;
        w_fault_addr_nxt = r_fault_addr;
        unique case (r_state)
            BOOT: begin
                if (RV_IN_RANGE) begin
                    w_state_nxt = FETCH;
                end else begin
                    w_state_nxt      = FAULT;
                    w_fault_code_nxt = FAULT_RANGE;
                    w_fault_addr_nxt = RESET_VECTOR;
                end
            end
            FETCH: begin
                // Any fault leaves the PC on the last good fetch address.
                if (halt_req) begin
                    w_state_nxt = HALTED;
                end else if (w_misaligned) begin
                    w_state_nxt      = FAULT;
                    w_fault_code_nxt = FAULT_MISALIGN;
                    w_fault_addr_nxt = w_cand_pc;
                end else if (w_range) begin
                    w_state_nxt      = FAULT;
                    w_fault_code_nxt = FAULT_RANGE;
                    w_fault_addr_nxt = w_cand_pc;
                end else begin
                    w_pc_nxt = w_cand_pc;
                end
            end
            default: begin
            end
        endcase
    end

`ifdef PC_FETCH_COUNTER_EN
    logic [31:0] r_fetch_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_count <= '0;
        end else if (r_state == FETCH && !stall && !halt_req) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign fetch_count = r_fetch_count;
`endif

    assign pc          = r_pc;
    assign pc_plus4    = r_pc + ADDRESS_WIDTH'(4);
    assign fetch_valid = (r_state == FETCH);
    assign halted      = (r_state == HALTED);
    assign fault       = (r_state == FAULT);
    assign fault_code  = r_fault_code;
    assign fault_addr  = r_fault_addr;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed and randomized checks of pc_fetch_unit against a behavioural model
module tb_pc_fetch_unit;

    localparam int          DEPTH = 64;
    localparam logic [31:0] RV    = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        halted;
    logic        fault;
    logic [1:0]  fault_code;
    logic [31:0] fault_addr;
`ifdef PC_FETCH_COUNTER_EN
    logic [31:0] fetch_count;
`endif

    int checks = 0;
    int errors = 0;

    // Model state: 0 boot, 1 fetching, 2 halted, 3 faulted.
    int          m_st;
    logic [31:0] m_pc;
    logic [1:0]  m_code;
    logic [31:0] m_addr;
    logic [31:0] m_cnt;

    pc_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt_req        (halt_req),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .fetch_valid     (fetch_valid),
        .halted          (halted),
        .fault           (fault),
        .fault_code      (fault_code),
`ifdef PC_FETCH_COUNTER_EN
        .fault_addr      (fault_addr),
        .fetch_count     (fetch_count)
`else
        .fault_addr      (fault_addr)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},          pc,                    m_pc);
        chk({tag, ".pc_plus4"},    pc_plus4,              m_pc + 32'd4);
        chk({tag, ".fetch_valid"}, 32'(fetch_valid),      32'(m_st == 1));
        chk({tag, ".halted"},      32'(halted),           32'(m_st == 2));
        chk({tag, ".fault"},       32'(fault),            32'(m_st == 3));
        chk({tag, ".fault_code"},  32'(fault_code),       32'(m_code));
        chk({tag, ".fault_addr"},  fault_addr,            m_addr);
`ifdef PC_FETCH_COUNTER_EN
        chk({tag, ".fetch_count"}, fetch_count,           m_cnt);
`endif
    endtask

    task automatic model_reset();
        m_st = 0; m_pc = RV; m_code = 2'b00; m_addr = 32'h0; m_cnt = 32'h0;
    endtask

    task automatic model_fault(input logic [1:0] code, input logic [31:0] addr);
        m_st = 3; m_code = code; m_addr = addr;
    endtask

    task automatic model_edge(input bit s, input bit rv, input logic [31:0] t, input bit h);
        logic [31:0] n;
        if (m_st == 0) begin
            if (RV / 4 >= DEPTH) model_fault(2'b10, RV);
            else m_st = 1;
        end else if (m_st == 1) begin
            if (!s && !h) m_cnt = m_cnt + 32'd1;
            if (h) m_st = 2;
            else if (rv && (t % 4) != 0) model_fault(2'b01, t);
            else if (rv && (t / 4) >= DEPTH) model_fault(2'b10, t);
            else if (rv) m_pc = t;
            else if (!s) begin
                n = m_pc + 32'd4;
                if (n / 4 >= DEPTH) model_fault(2'b10, n);
                else m_pc = n;
            end
        end
    endtask

    task automatic step(input bit s, input bit rv, input logic [31:0] t, input bit h, input string tag);
        stall = s; redirect_valid = rv; redirect_target = t; halt_req = h;
        @(posedge clk);
        model_edge(s, rv, t, h);
        #1;
        check_all(tag);
    endtask

    // Reset is raised mid-cycle to show it acts without a clock edge.
    task automatic do_reset();
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        stall = 0; redirect_valid = 0; redirect_target = 0; halt_req = 0;
        check_all("boot");
    endtask

    initial begin
        rst = 1'b1; stall = 0; redirect_valid = 0; redirect_target = 0; halt_req = 0;
        model_reset();
        @(posedge clk);
        #1;

        // Boot then sequential run, stall, redirect over stall
        do_reset();
        chk("boot_fetch_valid", 32'(fetch_valid), 32'd0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, "seq");
        chk("seq_pc_0x10", pc, 32'h10);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, "stall");
        chk("stall_hold", pc, 32'h10);
        step(1, 1, 32'h40, 0, "redir_over_stall");
        chk("redir_pc", pc, 32'h40);

        // Misaligned redirect at pc=0x8
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, "seq");
        step(0, 1, 32'h22, 0, "misalign");
        chk("misalign_code", 32'(fault_code), 32'd1);
        chk("misalign_addr", fault_addr, 32'h22);
        chk("misalign_pc", pc, 32'h8);
        for (int i = 0; i < 3; i++) step(0, 1, 32'h10, 0, "fault_sticky");

        // Sequential run off the end of memory
        do_reset();
        for (int i = 0; i < 64; i++) step(0, 0, 0, 0, "run");
        chk("run_pc_0xfc", pc, 32'hFC);
        step(0, 0, 0, 0, "seq_range");
        chk("seq_range_code", 32'(fault_code), 32'd2);
        chk("seq_range_addr", fault_addr, 32'h100);
        chk("seq_range_pc", pc, 32'hFC);

        // Redirect out of range
        do_reset();
        step(0, 0, 0, 0, "boot_edge");
        step(0, 1, 32'h200, 0, "redir_range");
        chk("redir_range_addr", fault_addr, 32'h200);
        chk("redir_range_code", 32'(fault_code), 32'd2);

        // Halt at 0x24 then ignore redirects, then async reset
        do_reset();
        step(0, 0, 0, 0, "boot_edge");
        step(0, 1, 32'h24, 0, "to_0x24");
        step(0, 0, 0, 1, "halt");
        chk("halt_flag", 32'(halted), 32'd1);
        for (int i = 0; i < 3; i++) step(0, 1, 32'h80, 0, "halted_ignore");
        chk("halt_pc", pc, 32'h24);
        do_reset();
        chk("reset_pc", pc, 32'h0);
        chk("reset_halted", 32'(halted), 32'd0);

        // Counter scenario: 10 fetch cycles, 2 stalled, then halt
        step(0, 0, 0, 0, "boot_edge");
        for (int i = 0; i < 10; i++) step((i == 3 || i == 7), 0, 0, 0, "cnt_run");
        step(0, 0, 0, 1, "cnt_halt");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, "cnt_frozen");
`ifdef PC_FETCH_COUNTER_EN
        chk("fetch_count_8", fetch_count, 32'd8);
`endif

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (m_st >= 2 && $urandom_range(0, 5) == 0) begin
                do_reset();
            end else begin
                logic [31:0] t;
                bit          rv;
                rv = ($urandom_range(0, 7) == 0);
                t  = 32'($urandom_range(0, 70)) << 2;
                if ($urandom_range(0, 5) == 0) t = t | 32'($urandom_range(1, 3));
                if ($urandom_range(0, 30) == 0) t = $urandom;
                step(($urandom_range(0, 3) == 0), rv, t, ($urandom_range(0, 60) == 0), "rand");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
